// File: rtl/lot_ticket_sender.sv
// Initiator for the lottery digit-entry protocol: sends a latched 5-digit BCD ticket
// one digit per insere pulse, then fim, waits, captures premio, and clears with fim_jogo.
module lot_ticket_sender #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned RES_WAIT   = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [19:0]      ticket,
  input  logic [1:0]       premio_in,
  output logic [3:0]       num,
  output logic             insere,
  output logic             fim,
  output logic             fim_jogo,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       last_premio,
  output logic [CNT_W-1:0] tickets_sent
);

  localparam int unsigned MAXC = (GAP_CYCLES > RES_WAIT) ? GAP_CYCLES : RES_WAIT;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, SEND, GAP, FIM, WAIT, CLEAR} state_t;

  state_t           state, state_d;
  logic [19:0]      sr, sr_d;
  logic [2:0]       idx, idx_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             completed, completed_d;
  logic [3:0]       num_d;
  logic             err_d, done_d;
  logic [1:0]       last_premio_d;
  logic [CNT_W-1:0] tickets_d;

  function automatic logic is_bcd(input logic [19:0] t);
    for (int unsigned i = 0; i < 5; i++)
      if (t[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Outputs are registered copies of next-state decodes, so they line up with the state.
  always_comb begin
    state_d       = state;
    sr_d          = sr;
    idx_d         = idx;
    cnt_d         = cnt;
    completed_d   = completed;
    num_d         = num;
    err_d         = err;
    done_d        = 1'b0;
    last_premio_d = last_premio;
    tickets_d     = tickets_sent;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (!is_bcd(ticket)) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            num_d   = ticket[19:16];
            sr_d    = {ticket[15:0], 4'h0};
            idx_d   = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        cnt_d   = CW'(GAP_CYCLES);
        state_d = GAP;
      end
      GAP: begin
        if (cnt == CW'(1)) begin
          if (idx == 3'd4) begin
            state_d = FIM;
          end else begin
            idx_d   = idx + 3'd1;
            num_d   = sr[19:16];
            sr_d    = {sr[15:0], 4'h0};
            state_d = SEND;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      FIM: begin
        cnt_d   = CW'(RES_WAIT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          last_premio_d = premio_in;
          completed_d   = 1'b1;
          state_d       = CLEAR;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      CLEAR: begin
        if (completed) begin
          done_d    = 1'b1;
          tickets_d = tickets_sent + CNT_W'(1);
        end
        completed_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Cancel overrides any in-flight step, including a same-cycle premio capture.
    if (cancel && (state == SEND || state == GAP || state == FIM || state == WAIT)) begin
      state_d       = CLEAR;
      completed_d   = 1'b0;
      last_premio_d = last_premio;
      num_d         = num;
    end
    if (state_d == IDLE) num_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sr           <= '0;
      idx          <= '0;
      cnt          <= '0;
      completed    <= 1'b0;
      num          <= '0;
      insere       <= 1'b0;
      fim          <= 1'b0;
      fim_jogo     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      last_premio  <= '0;
      tickets_sent <= '0;
    end else begin
      state        <= state_d;
      sr           <= sr_d;
      idx          <= idx_d;
      cnt          <= cnt_d;
      completed    <= completed_d;
      num          <= num_d;
      insere       <= (state_d == SEND);
      fim          <= (state_d == FIM);
      fim_jogo     <= (state_d == CLEAR);
      busy         <= (state_d != IDLE);
      done         <= done_d;
      err          <= err_d;
      last_premio  <= last_premio_d;
      tickets_sent <= tickets_d;
    end
  end

endmodule

// File: doc/lot_ticket_sender.md
Name: lot_ticket_sender

Overview:
- Initiator side of the lottery digit-entry protocol.
- Takes a 5-digit BCD ticket and drives it into the lottery checker one digit per `insere` pulse (`num` held stable).
- Then pulses `fim`, waits a fixed time, captures the checker's `premio` result, and pulses `fim_jogo` to clear the checker for the next ticket.
- Sits between the ticket-entry front end (switches/keypad) and the checker.

Parameters:
GAP_CYCLES, 1, idle cycles after each insere pulse before the next digit or fim; legal range >=1
RES_WAIT, 2, cycles waited after fim before premio is sampled; legal range >=1
CNT_W, 8, width of tickets_sent counter

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request to send ticket; sampled only in IDLE
cancel  in  1  abort current ticket
ticket  in  20  five BCD digits; digit1 = [19:16] ... digit5 = [3:0]
premio_in  in  2  checker result (00 none, 01 prize 1, 10 prize 2)
num  out  4  current digit to checker
insere  out  1  one-cycle digit-valid pulse
fim  out  1  one-cycle end-of-entry pulse
fim_jogo  out  1  one-cycle checker-clear pulse
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse after a completed ticket
err  out  1  sticky: last start carried a non-BCD digit
last_premio  out  2  premio captured for last completed ticket
tickets_sent  out  CNT_W  completed tickets, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0: num, insere, fim, fim_jogo, busy, done, err, last_premio, tickets_sent.
  - Reset applies immediately, including mid-operation.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, FIM, WAIT, CLEAR.
- IDLE:
  - done is high only in the first IDLE cycle after CLEAR of a completed ticket; otherwise 0.
  - On start=1 and cancel=0, check every nibble of ticket:
    - Any nibble >9: err<=1, stay IDLE, ticket not latched, no protocol activity.
    - Else: latch ticket, err<=0, digit index<=0, go to SEND.
  - start and cancel both 1 in IDLE: nothing happens.
- SEND (1 cycle):
  - insere=1; num=latched digit[index].
  - Go to GAP; gap counter loads GAP_CYCLES.
- GAP (GAP_CYCLES cycles):
  - insere=0; num holds the last digit.
  - On expiry: index<4 → index+1, SEND; index==4 → FIM.
- FIM (1 cycle): fim=1, insere=0 → WAIT; wait counter loads RES_WAIT.
- WAIT (RES_WAIT cycles): on the edge ending the last WAIT cycle, last_premio<=premio_in, then go to CLEAR.
- CLEAR (1 cycle):
  - fim_jogo=1.
  - Next edge: IDLE, done=1 for one cycle, tickets_sent+1 (wraps from all-ones to 0).
- Capture timing: premio must be captured before fim_jogo, because the checker zeroes premio on fim_jogo.
- Timing with defaults (start sampled at edge ending cycle 0):
  - insere in cycles 1, 3, 5, 7, 9 (digits 1–5).
  - fim in cycle 11; WAIT in cycles 12–13.
  - last_premio valid and fim_jogo high in cycle 14.
  - done in cycle 15.
  - busy high in cycles 1–14.
  - General total: 5*(1+GAP_CYCLES) + 1 + RES_WAIT + 1 cycles busy.
- cancel=1 in SEND, GAP, FIM or WAIT:
  - Next state is CLEAR with fim_jogo=1.
  - last_premio unchanged; tickets_sent unchanged; done not asserted on return to IDLE.
  - cancel is ignored in CLEAR.
- start while busy: ignored, not queued.
- ticket changes while busy: no effect; the latched copy is used.
- At most one of insere, fim, fim_jogo is high in any cycle.
- num returns to 0 in IDLE.

Test Plan:
1. Reset low 3 cycles, release → all outputs 0, busy=0.
2. ticket=0x47019, start 1 cycle, premio_in=01 from cycle 11:
   - num/insere = 4,7,0,1,9 in cycles 1,3,5,7,9; fim in cycle 11.
   - last_premio=01 and fim_jogo in cycle 14; done in cycle 15; tickets_sent=1.
3. ticket=0x4A019, start → err=1, busy stays 0, no insere/fim/fim_jogo. Then ticket=0x47019, start → err returns to 0 and the ticket is sent normally.
4. cancel asserted in cycle 4 (after the 2nd digit) → fim_jogo in cycle 5, IDLE in cycle 6, no done, tickets_sent and last_premio unchanged.
5. start re-pulsed in cycles 2 and 8 of a running ticket → ignored; exactly 5 insere pulses; a single done.
6. Mid-operation reset (cycle 6) → all outputs 0 immediately. Preload tickets_sent=255 via 255 completed runs (CNT_W=8), then complete one more → tickets_sent=0.
